// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: registers decode fields and selects forwarded ALU operands.
// Define FORWARDING_EN to enable EX/MEM and MEM/WB operand forwarding.
module alu_operand_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_AW     = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  id_valid,
   input  logic [DATA_WIDTH-1:0] id_rs_data,
   input  logic [DATA_WIDTH-1:0] id_rt_data,
   input  logic [DATA_WIDTH-1:0] id_imm,
   input  logic [4:0]            id_shamt,
   input  logic [REG_AW-1:0]     id_rs,
   input  logic [REG_AW-1:0]     id_rt,
   input  logic [REG_AW-1:0]     id_dest,
   input  logic [3:0]            id_alu_control,
   input  logic                  id_alu_src,
   input  logic                  id_shift,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  id_mem_write,
   input  logic                  id_mem_to_reg,
   input  logic                  exmem_reg_write,
   input  logic [REG_AW-1:0]     exmem_rd,
   input  logic [DATA_WIDTH-1:0] exmem_result,
   input  logic                  memwb_reg_write,
   input  logic [REG_AW-1:0]     memwb_rd,
   input  logic [DATA_WIDTH-1:0] memwb_result,
   output logic [DATA_WIDTH-1:0] operand1,
   output logic [DATA_WIDTH-1:0] operand2,
   output logic [3:0]            alu_control,
   output logic                  ex_valid,
   output logic                  ex_reg_write,
   output logic                  ex_mem_read,
   output logic                  ex_mem_write,
   output logic                  ex_mem_to_reg,
   output logic [REG_AW-1:0]     ex_dest,
   output logic [DATA_WIDTH-1:0] ex_store_data
);

   logic [DATA_WIDTH-1:0] rs_data, rt_data, imm;
   logic [4:0]            shamt;
   logic [REG_AW-1:0]     rs, rt;
   logic                  alu_src, shift;
   logic [DATA_WIDTH-1:0] rs_fwd, rt_fwd;
   logic                  bubble;

   // An invalid decode slot is treated exactly like a flush unless stalled.
   assign bubble = flush | (~stall & ~id_valid);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid      <= 1'b0;
         rs_data       <= '0;
         rt_data       <= '0;
         imm           <= '0;
         shamt         <= '0;
         rs            <= '0;
         rt            <= '0;
         ex_dest       <= '0;
         alu_control   <= '0;
         alu_src       <= 1'b0;
         shift         <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_mem_to_reg <= 1'b0;
      end else if (bubble) begin
         ex_valid      <= 1'b0;
         rs_data       <= '0;
         rt_data       <= '0;
         imm           <= '0;
         shamt         <= '0;
         rs            <= '0;
         rt            <= '0;
         ex_dest       <= '0;
         alu_control   <= '0;
         alu_src       <= 1'b0;
         shift         <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_mem_to_reg <= 1'b0;
      end else if (!stall) begin
         ex_valid      <= 1'b1;
         rs_data       <= id_rs_data;
         rt_data       <= id_rt_data;
         imm           <= id_imm;
         shamt         <= id_shamt;
         rs            <= id_rs;
         rt            <= id_rt;
         ex_dest       <= id_dest;
         alu_control   <= id_alu_control;
         alu_src       <= id_alu_src;
         shift         <= id_shift;
         ex_reg_write  <= id_reg_write;
         ex_mem_read   <= id_mem_read;
         ex_mem_write  <= id_mem_write;
         ex_mem_to_reg <= id_mem_to_reg;
      end
   end

`ifdef FORWARDING_EN
   // EX/MEM is the younger result, so it is checked first; r0 never forwards.
   always_comb begin
      rs_fwd = rs_data;
      if (exmem_reg_write && exmem_rd == rs && rs != '0)
         rs_fwd = exmem_result;
      else if (memwb_reg_write && memwb_rd == rs && rs != '0)
         rs_fwd = memwb_result;
   end

   always_comb begin
      rt_fwd = rt_data;
      if (exmem_reg_write && exmem_rd == rt && rt != '0)
         rt_fwd = exmem_result;
      else if (memwb_reg_write && memwb_rd == rt && rt != '0)
         rt_fwd = memwb_result;
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result,
                         memwb_reg_write, memwb_rd, memwb_result,
                         rs, rt};
   assign rs_fwd = rs_data;
   assign rt_fwd = rt_data;
`endif

   assign operand1      = shift ? DATA_WIDTH'(shamt) : rs_fwd;
   assign operand2      = alu_src ? imm : rt_fwd;
   assign ex_store_data = rt_fwd;

endmodule
